// File: rtl/root_hub_router.sv
// root_hub_router: switching core between the root controller stream and
// NUM_LEAVES leaf channels. Downstream messages are held in one register and
// delivered to each addressed leaf independently (unicast or broadcast);
// messages with an unroutable destination are dropped and counted. Upstream
// messages are collected round-robin into a single output register and may be
// tagged with the source leaf id (leaf index + 1).
module root_hub_router #(
    parameter int NUM_LEAVES    = 4,
    parameter int CHANNEL_WIDTH = 64,
    parameter int DEST_WIDTH    = 8,
    parameter int TAG_SOURCE    = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CHANNEL_WIDTH-1:0]            local_in_data,
    input  logic                                local_in_valid,
    output logic                                local_in_ready,
    output logic [CHANNEL_WIDTH-1:0]            local_out_data,
    output logic                                local_out_valid,
    input  logic                                local_out_ready,
    output logic [CHANNEL_WIDTH*NUM_LEAVES-1:0] leaf_tx_data,
    output logic [NUM_LEAVES-1:0]               leaf_tx_valid,
    input  logic [NUM_LEAVES-1:0]               leaf_tx_ready,
    input  logic [CHANNEL_WIDTH*NUM_LEAVES-1:0] leaf_rx_data,
    input  logic [NUM_LEAVES-1:0]               leaf_rx_valid,
    output logic [NUM_LEAVES-1:0]               leaf_rx_ready,
    output logic [15:0]                         drop_count
);

    localparam int PTR_W = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_DELIVER = 1'b1
    } ds_state_t;

    // ---------------- downstream path ----------------
    ds_state_t                 state_r;
    ds_state_t                 state_nxt_s;
    logic [CHANNEL_WIDTH-1:0]  hold_data_r;
    logic [NUM_LEAVES-1:0]     pending_r;
    logic [NUM_LEAVES-1:0]     pending_nxt_s;
    logic [NUM_LEAVES-1:0]     fire_s;
    logic [NUM_LEAVES-1:0]     remain_s;
    logic [NUM_LEAVES-1:0]     route_mask_s;
    logic                      routable_s;
    logic                      accept_s;
    logic [DEST_WIDTH-1:0]     dest_s;
    logic [15:0]               drop_count_r;

    // Destination decode: all-ones broadcasts, 1..NUM_LEAVES is unicast, anything else drops.
    always_comb begin
        dest_s       = local_in_data[CHANNEL_WIDTH-1 -: DEST_WIDTH];
        route_mask_s = {NUM_LEAVES{1'b0}};
        routable_s   = 1'b0;
        if (dest_s == {DEST_WIDTH{1'b1}}) begin
            route_mask_s = {NUM_LEAVES{1'b1}};
            routable_s   = 1'b1;
        end else begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (dest_s == DEST_WIDTH'(i + 1)) begin
                    route_mask_s[i] = 1'b1;
                    routable_s      = 1'b1;
                end else begin
                    route_mask_s[i] = route_mask_s[i];
                end
            end
        end
    end

    // Per-leaf delivery bookkeeping; a new message may enter on the edge the last leaf fires.
    always_comb begin
        fire_s         = pending_r & leaf_tx_ready;
        remain_s       = pending_r & ~fire_s;
        local_in_ready = (remain_s == {NUM_LEAVES{1'b0}});
        accept_s       = local_in_valid & local_in_ready;
        if (accept_s && routable_s) begin
            pending_nxt_s = route_mask_s;
        end else begin
            pending_nxt_s = remain_s;
        end
    end

    // Delivery FSM next state: DELIVER whenever any leaf still owes a transfer.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && routable_s) begin
                    state_nxt_s = ST_DELIVER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DELIVER: begin
                if (pending_nxt_s != {NUM_LEAVES{1'b0}}) begin
                    state_nxt_s = ST_DELIVER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Downstream registers: state, pending mask, held message and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            pending_r    <= {NUM_LEAVES{1'b0}};
            hold_data_r  <= {CHANNEL_WIDTH{1'b0}};
            drop_count_r <= 16'h0000;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            if (accept_s && routable_s) begin
                hold_data_r <= local_in_data;
            end
            if (accept_s && !routable_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'h0001;
            end
        end
    end

    assign leaf_tx_valid = pending_r;
    assign leaf_tx_data  = {NUM_LEAVES{hold_data_r}};
    assign drop_count    = drop_count_r;

    // ---------------- upstream path ----------------
    logic [PTR_W-1:0]          ptr_r;
    logic [PTR_W-1:0]          ptr_nxt_s;
    logic [PTR_W-1:0]          gidx_s;
    logic                      found_s;
    logic                      load_s;
    logic [CHANNEL_WIDTH-1:0]  sel_data_s;
    logic [CHANNEL_WIDTH-1:0]  tagged_data_s;
    logic [CHANNEL_WIDTH-1:0]  out_data_r;
    logic                      out_valid_r;

    // Round-robin grant: first valid leaf at or above ptr, else the lowest valid leaf (wrap).
    always_comb begin
        found_s = 1'b0;
        gidx_s  = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_LEAVES; i++) begin
            if (!found_s && leaf_rx_valid[i] && (PTR_W'(i) >= ptr_r)) begin
                found_s = 1'b1;
                gidx_s  = PTR_W'(i);
            end else begin
                gidx_s = gidx_s;
            end
        end
        for (int i = 0; i < NUM_LEAVES; i++) begin
            if (!found_s && leaf_rx_valid[i]) begin
                found_s = 1'b1;
                gidx_s  = PTR_W'(i);
            end else begin
                gidx_s = gidx_s;
            end
        end
    end

    // Pop handshake, granted leaf data selection, optional source tag and next pointer.
    always_comb begin
        load_s        = !out_valid_r | local_out_ready;
        leaf_rx_ready = {NUM_LEAVES{1'b0}};
        sel_data_s    = {CHANNEL_WIDTH{1'b0}};
        for (int i = 0; i < NUM_LEAVES; i++) begin
            if (gidx_s == PTR_W'(i)) begin
                sel_data_s       = leaf_rx_data[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                leaf_rx_ready[i] = load_s & found_s;
            end else begin
                leaf_rx_ready[i] = 1'b0;
            end
        end
        tagged_data_s = sel_data_s;
        if (TAG_SOURCE != 0) begin
            tagged_data_s[CHANNEL_WIDTH-1 -: DEST_WIDTH] = DEST_WIDTH'(gidx_s) + DEST_WIDTH'(1);
        end else begin
            tagged_data_s = sel_data_s;
        end
        if (gidx_s == PTR_W'(NUM_LEAVES - 1)) begin
            ptr_nxt_s = {PTR_W{1'b0}};
        end else begin
            ptr_nxt_s = gidx_s + PTR_W'(1);
        end
    end

    // Upstream output register and round-robin pointer; holds while valid and not ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r  <= {CHANNEL_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            ptr_r       <= {PTR_W{1'b0}};
        end else if (load_s) begin
            if (found_s) begin
                out_data_r  <= tagged_data_s;
                out_valid_r <= 1'b1;
                ptr_r       <= ptr_nxt_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign local_out_data  = out_data_r;
    assign local_out_valid = out_valid_r;

endmodule
